// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the add/sub arbiter: FSM state encoding and the
// tag-width helper used to size requester indices.
package addsub_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Ceiling log2, never less than 1 so a tag always has at least one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/addsub_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches upward from the last winner + 1 with wrap.
// The pointer moves only when the caller reports that the grant was taken.
import addsub_arbiter_pkg::*;

module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    w_idx;
  logic               w_found;
  logic [NUM_REQ-1:0] w_grant;

  always_comb begin
    int c;
    w_found = 1'b0;
    w_idx   = '0;
    c       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[c]) begin
        w_found = 1'b1;
        w_idx   = ID_W'(c);
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_found) w_grant[w_idx] = 1'b1;
  end

  // Reset value NUM_REQ-1 makes requester 0 the first candidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= ID_W'(NUM_REQ - 1);
    end else if (i_advance && w_found) begin
      r_ptr <= w_idx;
    end
  end

  assign o_grant = w_grant;
  assign o_idx   = w_idx;
  assign o_any   = w_found;

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one combinational add/sub unit between NUM_REQ requesters:
// grant -> drive adder for one cycle -> hold tagged response until taken.
import addsub_arbiter_pkg::*;

module addsub_arbiter #(
  parameter  int WIDTH   = 32,
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_rs1,
  input  logic [NUM_REQ*WIDTH-1:0] req_rs2,
  input  logic [NUM_REQ-1:0]       req_sub,
  input  logic                     flush,
  output logic [WIDTH-1:0]         add_rs1,
  output logic [WIDTH-1:0]         add_rs2,
  output logic                     add_en,
  output logic                     add_sub,
  input  logic [WIDTH-1:0]         add_result,
  input  logic                     add_overflow,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_overflow,
  output logic [ID_W-1:0]          rsp_id,
  output logic [1:0]               dbg_state
);

  // Handshakes: a request transfers on a cycle where req_valid[i] && req_ready[i];
  // a response transfers on a cycle where rsp_valid && rsp_ready, and rsp_*
  // stay frozen until then. req_ready never depends on req_ready itself.

  state_t             r_state;
  logic               r_add_en;
  logic [WIDTH-1:0]   r_add_rs1;
  logic [WIDTH-1:0]   r_add_rs2;
  logic               r_add_sub;
  logic [ID_W-1:0]    r_op_id;
  logic               r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_result;
  logic               r_rsp_overflow;
  logic [ID_W-1:0]    r_rsp_id;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic               w_arb_open;
  logic               w_grant_fire;
  logic [WIDTH-1:0]   w_sel_rs1;
  logic [WIDTH-1:0]   w_sel_rs2;
  logic               w_sel_sub;

  // Arbitration runs in IDLE, or in RESP on the cycle the response is taken.
  assign w_arb_open = !RST && !flush &&
                      ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready));
  assign w_grant_fire = w_arb_open && w_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clk       (CLK),
    .rst       (RST),
    .i_req     (req_valid),
    .i_advance (w_grant_fire),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_any     (w_any)
  );

  assign w_sel_rs1 = req_rs1[int'(w_idx)*WIDTH +: WIDTH];
  assign w_sel_rs2 = req_rs2[int'(w_idx)*WIDTH +: WIDTH];
  assign w_sel_sub = req_sub[w_idx];

  assign req_ready = w_arb_open ? w_grant : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state        <= ST_IDLE;
      r_add_en       <= 1'b0;
      r_add_rs1      <= '0;
      r_add_rs2      <= '0;
      r_add_sub      <= 1'b0;
      r_op_id        <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
      r_rsp_id       <= '0;
    end else begin
      // Adder drive is non-zero only during the single EXEC cycle.
      r_add_en  <= 1'b0;
      r_add_rs1 <= '0;
      r_add_rs2 <= '0;
      r_add_sub <= 1'b0;
      if (flush) begin
        r_state     <= ST_IDLE;
        r_rsp_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_EXEC: begin
            r_rsp_result   <= add_result;
            r_rsp_overflow <= add_overflow;
            r_rsp_id       <= r_op_id;
            r_rsp_valid    <= 1'b1;
            r_state        <= ST_RESP;
          end
          ST_RESP: begin
            if (rsp_ready) begin
              r_rsp_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
        if (w_grant_fire) begin
          r_state   <= ST_EXEC;
          r_add_en  <= 1'b1;
          r_add_rs1 <= w_sel_rs1;
          r_add_rs2 <= w_sel_rs2;
          r_add_sub <= w_sel_sub;
          r_op_id   <= w_idx;
        end
      end
    end
  end

  assign add_en       = r_add_en;
  assign add_rs1      = r_add_rs1;
  assign add_rs2      = r_add_rs2;
  assign add_sub      = r_add_sub;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_rsp_result;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_id       = r_rsp_id;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_addsub_arbiter;

  localparam int W = 32;
  localparam int N = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_rs1;
  logic [N*W-1:0] req_rs2;
  logic [N-1:0]   req_sub;
  logic           flush;
  logic [W-1:0]   add_rs1;
  logic [W-1:0]   add_rs2;
  logic           add_en;
  logic           add_sub;
  logic [W-1:0]   add_result;
  logic           add_overflow;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_result;
  logic           rsp_overflow;
  logic [0:0]     rsp_id;
  logic [1:0]     dbg_state;

  int n_cmp;
  int n_bad;

  addsub_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .CLK          (clk),
    .RST          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_sub      (req_sub),
    .flush        (flush),
    .add_rs1      (add_rs1),
    .add_rs2      (add_rs2),
    .add_en       (add_en),
    .add_sub      (add_sub),
    .add_result   (add_result),
    .add_overflow (add_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_id       (rsp_id),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared adder (environment, carry-based) ----------------
  logic [W-1:0] env_b;
  logic [W:0]   env_sum;
  logic         env_cin_msb;
  assign env_b        = add_sub ? ~add_rs2 : add_rs2;
  assign env_sum      = {1'b0, add_rs1} + {1'b0, env_b} + {{W{1'b0}}, add_sub};
  assign env_cin_msb  = add_rs1[W-1] ^ env_b[W-1] ^ env_sum[W-1];
  assign add_result   = env_sum[W-1:0];
  assign add_overflow = env_sum[W] ^ env_cin_msb;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    return s ? (a - b) : (a + b);
  endfunction

  // Signed overflow by the sign rule: operands (effective) agree, result differs.
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] r;
    r = ref_res(a, b, s);
    if (s) return (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] word_of(input logic [N*W-1:0] vec, input int i);
    return vec[i*W +: W];
  endfunction

  int           m_ptr;
  logic         m_live;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic         m_s;
  int           m_id;
  logic         m_rv;
  logic [W-1:0] m_res;
  logic         m_ovf;
  int           m_rid;

  function automatic logic arb_open();
    return !rst && !flush && !m_live && (!m_rv || rsp_ready);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ptr  <= N - 1;
      m_live <= 1'b0;
      m_rv   <= 1'b0;
      m_res  <= '0;
      m_ovf  <= 1'b0;
      m_rid  <= 0;
      m_a    <= '0;
      m_b    <= '0;
      m_s    <= 1'b0;
      m_id   <= 0;
    end else if (flush) begin
      m_live <= 1'b0;
      m_rv   <= 1'b0;
    end else if (m_live) begin
      m_live <= 1'b0;
      m_rv   <= 1'b1;
      m_res  <= ref_res(m_a, m_b, m_s);
      m_ovf  <= ref_ovf(m_a, m_b, m_s);
      m_rid  <= m_id;
    end else if (arb_open()) begin
      m_rv <= 1'b0;
      if (pick(req_valid, m_ptr) >= 0) begin
        m_live <= 1'b1;
        m_ptr  <= pick(req_valid, m_ptr);
        m_id   <= pick(req_valid, m_ptr);
        m_a    <= word_of(req_rs1, pick(req_valid, m_ptr));
        m_b    <= word_of(req_rs2, pick(req_valid, m_ptr));
        m_s    <= req_sub[pick(req_valid, m_ptr)];
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  logic check_en;
  initial check_en = 1'b0;

  always @(negedge clk) begin
    if (check_en) begin
      int w;
      logic [N-1:0] er;
      w  = pick(req_valid, m_ptr);
      er = '0;
      if (arb_open() && w >= 0) er[w] = 1'b1;
      chk("req_ready",    W'(req_ready),    W'(er));
      chk("add_en",       W'(add_en),       W'(m_live));
      chk("add_rs1",      add_rs1,          m_live ? m_a : '0);
      chk("add_rs2",      add_rs2,          m_live ? m_b : '0);
      chk("add_sub",      W'(add_sub),      W'(m_live & m_s));
      chk("rsp_valid",    W'(rsp_valid),    W'(m_rv));
      chk("rsp_result",   rsp_result,       m_res);
      chk("rsp_overflow", W'(rsp_overflow), W'(m_ovf));
      chk("rsp_id",       W'(rsp_id),       W'(m_rid));
      chk("dbg_state",    W'(dbg_state),    m_live ? 32'd1 : (m_rv ? 32'd2 : 32'd0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    req_rs1[i*W +: W] = a;
    req_rs2[i*W +: W] = b;
    req_sub[i]        = s;
  endtask

  logic [W-1:0] held_res;
  logic         held_ovf;
  logic [0:0]   held_id;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    req_rs1   = '0;
    req_rs2   = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    cyc();
    check_en = 1'b1;
    cyc();
    chk("reset_rsp_valid", W'(rsp_valid), 32'd0);
    chk("reset_add_en",    W'(add_en),    32'd0);
    rst = 1'b0;

    // Single add: 5 + 7 from requester 0.
    set_req(0, 32'd5, 32'd7, 1'b0);
    req_valid = 2'b01;
    #1 chk("add_ready_same_cycle", W'(req_ready), 32'h1);
    cyc();
    req_valid = 2'b00;
    chk("add_en_next_cycle", W'(add_en), 32'd1);
    chk("add_rs1_drive", add_rs1, 32'd5);
    cyc();
    chk("add_rsp_valid", W'(rsp_valid), 32'd1);
    chk("add_result", rsp_result, 32'd12);
    chk("add_ovf", W'(rsp_overflow), 32'd0);
    chk("add_id", W'(rsp_id), 32'd0);
    cyc();

    // Signed overflow on subtract then on add, both from requester 1.
    set_req(1, 32'h8000_0000, 32'd1, 1'b1);
    req_valid = 2'b10;
    cyc();
    req_valid = 2'b00;
    cyc();
    chk("sub_ovf_result", rsp_result, 32'h7FFF_FFFF);
    chk("sub_ovf_flag", W'(rsp_overflow), 32'd1);
    chk("sub_ovf_id", W'(rsp_id), 32'd1);
    cyc();
    set_req(1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    req_valid = 2'b10;
    cyc();
    req_valid = 2'b00;
    cyc();
    chk("add_ovf_result", rsp_result, 32'h8000_0000);
    chk("add_ovf_flag", W'(rsp_overflow), 32'd1);
    cyc();

    // Fairness: both valid, grants alternate 0,1,... one per 2 cycles.
    set_req(0, 32'd100, 32'd1, 1'b0);
    set_req(1, 32'd200, 32'd2, 1'b1);
    req_valid = 2'b11;
    for (int k = 0; k < 16; k++) begin
      logic [1:0] er;
      #1;
      er = (k % 2 == 0) ? ((((k / 2) % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk("fair_grant", W'(req_ready), W'(er));
      cyc();
    end
    req_valid = 2'b00;
    cyc();
    cyc();

    // Backpressure: response held for 3 cycles, then next grant same cycle.
    rsp_ready = 1'b0;
    set_req(0, 32'd40, 32'd2, 1'b0);
    req_valid = 2'b01;
    cyc();
    cyc();
    held_res = rsp_result;
    held_ovf = rsp_overflow;
    held_id  = rsp_id;
    chk("bp_result", held_res, 32'd42);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_ready", W'(req_ready), 32'd0);
      chk("bp_add_en", W'(add_en), 32'd0);
      chk("bp_hold", rsp_result, held_res);
      chk("bp_hold_ovf", W'(rsp_overflow), W'(held_ovf));
      chk("bp_hold_id", W'(rsp_id), W'(held_id));
    end
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1 chk("bp_release_grant", W'(req_ready), 32'h2);
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();

    // Flush in EXEC: no response; the pointer still advanced past requester 0.
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    flush = 1'b1;
    #1 chk("flush_ready", W'(req_ready), 32'd0);
    cyc();
    flush = 1'b0;
    chk("flush_no_rsp", W'(rsp_valid), 32'd0);
    chk("flush_idle", W'(dbg_state), 32'd0);
    set_req(1, 32'd9, 32'd4, 1'b1);
    req_valid = 2'b11;
    #1 chk("flush_next_grant", W'(req_ready), 32'h2);
    cyc();
    req_valid = 2'b00;
    cyc();
    chk("flush_next_result", rsp_result, 32'd5);
    cyc();

    // Reset while a response is pending.
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    cyc();
    req_valid = 2'b00;
    cyc();
    chk("rst_pre_valid", W'(rsp_valid), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rsp_ready = 1'b1;
    chk("rst_rsp_valid", W'(rsp_valid), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    req_valid = 2'b11;
    #1 chk("rst_first_grant", W'(req_ready), 32'h1);
    cyc();

    // Random traffic checked cycle by cycle against the model.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0:       set_req(i, 32'h7FFF_FFFF, $urandom_range(0, 2), $urandom_range(0, 1) == 1);
          1:       set_req(i, 32'h8000_0000, $urandom_range(0, 2), $urandom_range(0, 1) == 1);
          default: set_req(i, $urandom(), $urandom(), $urandom_range(0, 1) == 1);
        endcase
      end
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      rsp_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 4);
      rst       = ($urandom_range(0, 99) < 1);
      cyc();
    end
    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    cyc();
    check_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
